// File: rtl/out_port_sched.sv
// rtl/out_port_sched.sv - packet-granular round-robin scheduler driving an output-port read mux
// Picks a requesting input port, steers the mux, pulses its read grant, then waits for EOP or watchdog.

module out_port_sched #(
    parameter int IN_PORT_NUM = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_en,
    input  logic [IN_PORT_NUM-1:0]         i_req,
    output logic [$clog2(IN_PORT_NUM)-1:0] o_sel,
    output logic                           o_sel_vld,
    output logic [IN_PORT_NUM-1:0]         o_grant,
    input  logic                           i_rd_vld,
    input  logic                           i_rd_eop,
    output logic                           o_busy,
    output logic                           o_timeout
);

    localparam int SW = $clog2(IN_PORT_NUM);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL   = 2'd1,
        GRANT = 2'd2,
        XFER  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [SW-1:0]          rr_ptr;
    logic [SW-1:0]          rr_nx;
    logic [WW-1:0]          wd;
    logic [WW-1:0]          wd_nx;
    logic [SW-1:0]          sel_nx;
    logic                   sel_vld_nx;
    logic [IN_PORT_NUM-1:0] grant_nx;
    logic                   timeout_nx;
    logic [SW-1:0]          win;
    logic                   win_found;
    logic [SW-1:0]          idx;

    // Search starts one past the last served port; index arithmetic wraps because N is a power of two.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int i = 1; i <= IN_PORT_NUM; i++) begin
            idx = rr_ptr + SW'(i);
            if (!win_found && i_req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    // o_sel keeps the current winner through the transfer, so it doubles as the completion port.
    always_comb begin
        state_nx   = state;
        rr_nx      = rr_ptr;
        wd_nx      = wd;
        sel_nx     = o_sel;
        sel_vld_nx = 1'b0;
        grant_nx   = '0;
        timeout_nx = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nx   = SEL;
                    sel_nx     = win;
                    sel_vld_nx = 1'b1;
                end
            end
            SEL: begin
                state_nx = GRANT;
                grant_nx = {{(IN_PORT_NUM-1){1'b0}}, 1'b1} << o_sel;
            end
            GRANT: begin
                state_nx = XFER;
                wd_nx    = '0;
            end
            XFER: begin
                if (i_rd_vld && i_rd_eop) begin
                    state_nx = IDLE;
                    rr_nx    = o_sel;
                end else if (wd == WD_LAST) begin
                    state_nx   = IDLE;
                    rr_nx      = o_sel;
                    timeout_nx = 1'b1;
                end else begin
                    wd_nx = wd + WW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Disable clears everything like reset but keeps rr_ptr so fairness survives a soft reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            rr_ptr    <= '1;
            wd        <= '0;
            o_sel     <= '0;
            o_sel_vld <= 1'b0;
            o_grant   <= '0;
            o_busy    <= 1'b0;
            o_timeout <= 1'b0;
        end else if (!i_en) begin
            state     <= IDLE;
            wd        <= '0;
            o_sel     <= '0;
            o_sel_vld <= 1'b0;
            o_grant   <= '0;
            o_busy    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_nx;
            wd        <= wd_nx;
            o_sel     <= sel_nx;
            o_sel_vld <= sel_vld_nx;
            o_grant   <= grant_nx;
            o_busy    <= (state_nx != IDLE);
            o_timeout <= timeout_nx;
        end
    end

endmodule
